// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants: FSM state encoding and tick divisor.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_t;

    // 10 ms tick at a 100 MHz system clock; the tick generator uses this too
    localparam int TICK_DVSR = 10**6;

endpackage

// File: rtl/stopwatch_ctrl_rise_detect.sv
// Rising-edge detector for one debounced button level.
// A level already high when reset is released yields one rise on the first clk.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev;

    // Remember last cycle's level so a fresh press can be told from a held one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns start/stop, lap and clear buttons into counter
// enable, counter clear and display-hold controls. Clearing while counting needs
// a long press on btn_clr so a brushed button cannot wipe a running time.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LONG_PRESS_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_clr,
    output logic       count_en,
    output logic       count_clr,
    output logic       display_hold,
    output logic [1:0] state_o
);

    localparam int CNT_W = $clog2(LONG_PRESS_TICKS + 1);
    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(LONG_PRESS_TICKS);

    sw_state_t        state_reg;
    sw_state_t        state_next;
    logic             clr_next;
    logic             rise_ss;
    logic             rise_lap;
    logic             rise_clr;
    logic [CNT_W-1:0] lp_cnt;
    logic             lp_fired;
    logic             lp_fire;
    logic             counting;

    rise_detect u_rise_ss (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_ss),
        .rise (rise_ss)
    );

    rise_detect u_rise_lap (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_lap),
        .rise (rise_lap)
    );

    rise_detect u_rise_clr (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_clr),
        .rise (rise_clr)
    );

    assign counting = (state_reg == RUN) || (state_reg == LAP);

    // The fired flag makes one continuous hold produce only one clear
    assign lp_fire = counting && (lp_cnt == LP_MAX) && !lp_fired;

    // Long-press timer: counts ticks while clear is held in a counting state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lp_cnt   <= '0;
            lp_fired <= 1'b0;
        end else begin
            if (!btn_clr || !counting) begin
                lp_cnt <= '0;
            end else if (tick && (lp_cnt != LP_MAX)) begin
                lp_cnt <= lp_cnt + CNT_W'(1);
            end

            if (!btn_clr) begin
                lp_fired <= 1'b0;
            end else if (lp_fire) begin
                lp_fired <= 1'b1;
            end
        end
    end

    // State register plus the registered one-cycle clear pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            count_clr <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_clr <= clr_next;
        end
    end

    // Next-state decode; clear beats start/stop, which beats lap, losers are dropped
    always_comb begin
        state_next = state_reg;
        clr_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rise_clr) begin
                    clr_next = 1'b1;
                end else if (rise_ss) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (lp_fire) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end else if (rise_ss) begin
                    state_next = PAUSE;
                end else if (rise_lap) begin
                    state_next = LAP;
                end
            end
            LAP: begin
                if (lp_fire) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end else if (rise_ss) begin
                    state_next = PAUSE;
                end else if (rise_lap) begin
                    state_next = RUN;
                end
            end
            PAUSE: begin
                if (rise_clr) begin
                    state_next = IDLE;
                    clr_next   = 1'b1;
                end else if (rise_ss) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign count_en     = counting;
    assign display_hold = (state_reg == LAP);
    assign state_o      = state_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: a default instance (100-tick long press)
// and a short one (3 ticks) share stimulus; a reference model pushes expected
// outputs into a queue as each cycle is driven, popped after the clock edge.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clr = 1'b0;

    logic       count_en, count_clr, display_hold;
    logic [1:0] state_o;
    logic       count_en3, count_clr3, display_hold3;
    logic [1:0] state_o3;

    int         nChecks = 0;
    int         nFails = 0;
    int         clrSeenMain = 0;
    int         clrSeenShort = 0;

    logic [1:0] mState [2];
    int         mCnt   [2];
    bit         mFired [2];
    int         lpN    [2] = '{100, 3};
    bit         pSs, pLap, pClr;
    logic [9:0] expQ [$];

    stopwatch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_ss      (btn_ss),
        .btn_lap     (btn_lap),
        .btn_clr     (btn_clr),
        .count_en    (count_en),
        .count_clr   (count_clr),
        .display_hold(display_hold),
        .state_o     (state_o)
    );

    stopwatch_ctrl #(.LONG_PRESS_TICKS(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .btn_ss      (btn_ss),
        .btn_lap     (btn_lap),
        .btn_clr     (btn_clr),
        .count_en    (count_en3),
        .count_clr   (count_clr3),
        .display_hold(display_hold3),
        .state_o     (state_o3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            mState[k] = 2'd0;
            mCnt[k]   = 0;
            mFired[k] = 1'b0;
        end
        pSs  = 1'b0;
        pLap = 1'b0;
        pClr = 1'b0;
    endtask

    // Reference behaviour for one clock edge; outputs packed {en, clr, hold, state}
    task automatic modelStep(input bit ss, input bit lap, input bit clr, input bit tk);
        bit         rss, rlap, rclr, active, fire, pulse;
        logic [1:0] ns;
        logic [4:0] o [2];
        rss  = ss  && !pSs;
        rlap = lap && !pLap;
        rclr = clr && !pClr;
        for (int k = 0; k < 2; k++) begin
            active = (mState[k] == 2'd1) || (mState[k] == 2'd2);
            fire   = active && (mCnt[k] == lpN[k]) && !mFired[k];
            pulse  = 1'b0;
            ns     = mState[k];
            if (mState[k] == 2'd0) begin
                if (rclr) pulse = 1'b1;
                else if (rss) ns = 2'd1;
            end else if (mState[k] == 2'd3) begin
                if (rclr) begin ns = 2'd0; pulse = 1'b1; end
                else if (rss) ns = 2'd1;
            end else begin
                if (fire) begin ns = 2'd0; pulse = 1'b1; end
                else if (rss) ns = 2'd3;
                else if (rlap) ns = (mState[k] == 2'd1) ? 2'd2 : 2'd1;
            end
            if (!clr || !active) mCnt[k] = 0;
            else if (tk && mCnt[k] < lpN[k]) mCnt[k] = mCnt[k] + 1;
            if (!clr) mFired[k] = 1'b0;
            else if (fire) mFired[k] = 1'b1;
            mState[k] = ns;
            o[k] = {(ns == 2'd1 || ns == 2'd2), pulse, (ns == 2'd2), ns};
        end
        pSs  = ss;
        pLap = lap;
        pClr = clr;
        expQ.push_back({o[1], o[0]});
    endtask

    // Drive one cycle from a falling edge, then compare at the next falling edge
    task automatic applyStimulus(input bit ss, input bit lap, input bit clr, input bit tk);
        logic [9:0] e;
        btn_ss  = ss;
        btn_lap = lap;
        btn_clr = clr;
        tick    = tk;
        modelStep(ss, lap, clr, tk);
        @(posedge clk);
        @(negedge clk);
        e = expQ.pop_front();
        checkOutput("main_out", 32'({count_en, count_clr, display_hold, state_o}), 32'(e[4:0]));
        checkOutput("short_out", 32'({count_en3, count_clr3, display_hold3, state_o3}), 32'(e[9:5]));
        if (count_clr)  clrSeenMain++;
        if (count_clr3) clrSeenShort++;
    endtask

    task automatic pressSs();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
    endtask

    initial begin
        bit rs, rl, rc;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset_main", 32'({count_en, count_clr, display_hold, state_o}), 32'd0);
        checkOutput("reset_short", 32'({count_en3, count_clr3, display_hold3, state_o3}), 32'd0);
        rst_n = 1'b1;

        $display("[TB] start/stop press");
        repeat (5) applyStimulus(1, 0, 0, 0);
        checkOutput("t1_en", 32'(count_en), 32'd1);
        checkOutput("t1_state", 32'(state_o), 32'd1);
        checkOutput("t1_clr_seen", 32'(clrSeenMain), 32'd0);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] lap toggle");
        repeat (2) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_hold", 32'(display_hold), 32'd1);
        checkOutput("t2_state", 32'(state_o), 32'd2);
        checkOutput("t2_en", 32'(count_en), 32'd1);
        repeat (2) applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t2_hold_off", 32'(display_hold), 32'd0);
        checkOutput("t2_state_run", 32'(state_o), 32'd1);

        $display("[TB] long press in RUN");
        clrSeenMain = 0;
        repeat (99) applyStimulus(0, 0, 1, 1);
        checkOutput("t3_state_99", 32'(state_o), 32'd1);
        checkOutput("t3_clr_99", 32'(clrSeenMain), 32'd0);
        applyStimulus(0, 0, 1, 1);
        applyStimulus(0, 0, 1, 0);
        checkOutput("t3_fire_clr", 32'(count_clr), 32'd1);
        checkOutput("t3_fire_state", 32'(state_o), 32'd0);
        repeat (300) applyStimulus(0, 0, 1, 1);
        checkOutput("t3_one_pulse", 32'(clrSeenMain), 32'd1);
        applyStimulus(0, 0, 0, 0);

        $display("[TB] clear and start/stop together in PAUSE");
        pressSs();
        pressSs();
        checkOutput("t4_pause", 32'(state_o), 32'd3);
        applyStimulus(1, 0, 1, 0);
        checkOutput("t4_clr", 32'(count_clr), 32'd1);
        checkOutput("t4_state", 32'(state_o), 32'd0);
        checkOutput("t4_en", 32'(count_en), 32'd0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t4_clr_once", 32'(count_clr), 32'd0);

        $display("[TB] asynchronous reset while running");
        pressSs();
        repeat (2) applyStimulus(0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_main", 32'({count_en, count_clr, display_hold, state_o}), 32'd0);
        checkOutput("t5_async_short", 32'({count_en3, count_clr3, display_hold3, state_o3}), 32'd0);
        @(negedge clk);
        checkOutput("t5_no_clr", 32'({count_clr, count_clr3}), 32'd0);
        modelReset();
        btn_lap = 1'b0;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0);

        $display("[TB] short long-press restart");
        pressSs();
        clrSeenShort = 0;
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, (i % 2) == 0);
        repeat (2) applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, (i % 2) == 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("t6_state", 32'(state_o3), 32'd1);
        checkOutput("t6_no_clr", 32'(clrSeenShort), 32'd0);

        $display("[TB] random button activity");
        rs = 0; rl = 0; rc = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7) == 0) rs = ~rs;
            if ($urandom_range(7) == 0) rl = ~rl;
            if ($urandom_range(15) == 0) rc = ~rc;
            applyStimulus(rs, rl, rc, $urandom_range(1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
